// File: rtl/mac_pkg.sv
// Shared definitions for the mac_seq multiply-accumulate block.
//   mac_state_e : FSM state encoding (IDLE, ACCUM, SCALE).
//   acc_width() : accumulator width that cannot overflow for a given
//                 weight width and neighbour count.
package mac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_SCALE = 2'd2
    } mac_state_e;

    // Bias plus up to n terms of magnitude <= 2^(wp-1) fit in wp + clog2(n+1)
    // bits; one extra bit is kept so negating the most negative weight is exact.
    function automatic int acc_width(input int wp, input int n);
        return wp + $clog2(n + 1) + 1;
    endfunction

endpackage

// File: rtl/mac_seq_if.sv
// Request/result bundle for mac_seq.
//   start     : requester -> mac_seq, ask for one evaluation
//   p_in      : requester -> mac_seq, p-bits (1 = +1, 0 = -1)
//   I_0       : requester -> mac_seq, unsigned fixed-point scale
//   busy      : mac_seq -> requester, evaluation in progress
//   out_valid : mac_seq -> requester, one-cycle pulse with a new out
//   out       : mac_seq -> requester, signed saturated result
//   state     : mac_seq -> observer, current FSM state (debug)
//
// Handshake: busy acts as an inverted ready. A request is taken on a rising
// edge where start=1 and busy=0; p_in and I_0 are captured on that same edge
// and may change freely afterwards. start while busy=1 is dropped, not queued.
// out is valid on every cycle out_valid=1 and holds until the next result.
interface mac_seq_if
    import mac_pkg::*;
#(
    parameter int N_NEIGHBORS      = 4,
    parameter int I0_WIDTH         = 4,
    parameter int WEIGHT_PRECISION = 6
) ();

    logic                               start;
    logic        [N_NEIGHBORS-1:0]      p_in;
    logic        [I0_WIDTH-1:0]         I_0;
    logic                               busy;
    logic                               out_valid;
    logic signed [WEIGHT_PRECISION-1:0] out;
    mac_state_e                         state;

    modport master (
        output start, p_in, I_0,
        input  busy, out_valid, out, state
    );

    modport slave (
        input  start, p_in, I_0,
        output busy, out_valid, out, state
    );

endinterface

// File: rtl/pbit_sat.sv
// Signed saturation from IN_W bits down to WEIGHT_PRECISION bits.
//   in_v  : signed value to clamp
//   out_v : in_v clamped to [-2^(WP-1), 2^(WP-1)-1]
module pbit_sat #(
    parameter int IN_W             = 16,
    parameter int WEIGHT_PRECISION = 6
) (
    input  logic signed [IN_W-1:0]             in_v,
    output logic signed [WEIGHT_PRECISION-1:0] out_v
);

    localparam logic signed [IN_W-1:0] MAX_V =
        {{(IN_W - WEIGHT_PRECISION + 1){1'b0}}, {(WEIGHT_PRECISION - 1){1'b1}}};
    localparam logic signed [IN_W-1:0] MIN_V =
        {{(IN_W - WEIGHT_PRECISION + 1){1'b1}}, {(WEIGHT_PRECISION - 1){1'b0}}};

    always_comb begin
        out_v = in_v[WEIGHT_PRECISION-1:0];
        if (in_v > MAX_V) begin
            out_v = MAX_V[WEIGHT_PRECISION-1:0];
        end else if (in_v < MIN_V) begin
            out_v = MIN_V[WEIGHT_PRECISION-1:0];
        end
    end

endmodule

// File: rtl/mac_seq.sv
// Sequential multiply-accumulate: out = sat(floor(I_0 * (H + sum(+/-W[i])) / 2^I0_FRAC)).
// One weight is folded in per cycle through a single shared adder.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : request/result bundle (slave side), see mac_seq_if
module mac_seq
    import mac_pkg::*;
#(
    parameter int N_NEIGHBORS      = 4,
    parameter int WEIGHT_PRECISION = 6,
    parameter int I0_WIDTH         = 4,
    parameter int I0_FRAC          = 2,
    parameter logic signed [WEIGHT_PRECISION-1:0]             H = 6'd2,
    parameter logic [N_NEIGHBORS*WEIGHT_PRECISION-1:0]        W = {6'd1, 6'd1, 6'd1, 6'd3}
) (
    input  logic     clk,
    input  logic     rst_n,
    mac_seq_if.slave bus
);

    localparam int WP     = WEIGHT_PRECISION;
    localparam int ACC_W  = acc_width(WEIGHT_PRECISION, N_NEIGHBORS);
    localparam int IDX_W  = (N_NEIGHBORS > 1) ? $clog2(N_NEIGHBORS) : 1;
    localparam int PROD_W = ACC_W + I0_WIDTH + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEIGHBORS - 1);

    mac_state_e                state_q, state_d;
    logic [N_NEIGHBORS-1:0]    p_q, p_d;
    logic [I0_WIDTH-1:0]       i0_q, i0_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic signed [WP-1:0]      out_q, out_d;
    logic                      out_valid_q, out_valid_d;

    logic signed [WP-1:0]      w_sel;
    logic signed [ACC_W-1:0]   w_ext;
    logic signed [ACC_W-1:0]   addend;
    logic signed [ACC_W-1:0]   acc_sum;
    logic signed [ACC_W-1:0]   h_ext;
    logic signed [PROD_W-1:0]  acc_ext;
    logic signed [PROD_W-1:0]  i0_ext;
    logic signed [PROD_W-1:0]  product;
    logic signed [PROD_W-1:0]  scaled;
    logic signed [WP-1:0]      sat_out;

    // Datapath: the weight is widened before negation so -(-2^(WP-1)) is exact.
    always_comb begin
        w_sel   = W[WP*idx_q +: WP];
        w_ext   = {{(ACC_W - WP){w_sel[WP-1]}}, w_sel};
        addend  = p_q[idx_q] ? w_ext : -w_ext;
        acc_sum = acc_q + addend;
        h_ext   = {{(ACC_W - WP){H[WP-1]}}, H};
        acc_ext = {{(PROD_W - ACC_W){acc_q[ACC_W-1]}}, acc_q};
        i0_ext  = {{(PROD_W - I0_WIDTH){1'b0}}, i0_q};
        product = acc_ext * i0_ext;
        // Arithmetic shift floors toward minus infinity.
        scaled  = product >>> I0_FRAC;
    end

    pbit_sat #(
        .IN_W             (PROD_W),
        .WEIGHT_PRECISION (WP)
    ) u_sat (
        .in_v  (scaled),
        .out_v (sat_out)
    );

    always_comb begin
        state_d     = state_q;
        p_d         = p_q;
        i0_d        = i0_q;
        acc_d       = acc_q;
        idx_d       = idx_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    p_d     = bus.p_in;
                    i0_d    = bus.I_0;
                    acc_d   = h_ext;
                    idx_d   = '0;
                    state_d = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                acc_d = acc_sum;
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = ST_SCALE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_SCALE: begin
                out_d       = sat_out;
                out_valid_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            p_q         <= '0;
            i0_q        <= '0;
            acc_q       <= '0;
            idx_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            p_q         <= p_d;
            i0_q        <= i0_d;
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out       = out_q;
    assign bus.state     = state_q;

endmodule

// File: tb/tb_mac_seq.sv
// Bench for mac_seq: three instances (default weights, all -2 weights with
// WP=5, and a single most-negative weight with WP=5) checked by per-instance
// scoreboards that compare value and arrival cycle of every out_valid.
module tb_mac_seq;
    import mac_pkg::*;

    localparam int N = 4;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   errors;

    logic [5:0] exp_a_q[$];
    logic [4:0] exp_b_q[$];
    logic [4:0] exp_c_q[$];
    int         cyc_a_q[$];
    int         cyc_b_q[$];
    int         cyc_c_q[$];

    mac_seq_if #(.N_NEIGHBORS(N), .I0_WIDTH(4), .WEIGHT_PRECISION(6)) bus_a ();
    mac_seq_if #(.N_NEIGHBORS(N), .I0_WIDTH(4), .WEIGHT_PRECISION(5)) bus_b ();
    mac_seq_if #(.N_NEIGHBORS(N), .I0_WIDTH(4), .WEIGHT_PRECISION(5)) bus_c ();

    mac_seq u_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    mac_seq #(
        .N_NEIGHBORS      (N),
        .WEIGHT_PRECISION (5),
        .I0_WIDTH         (4),
        .I0_FRAC          (2),
        .H                (5'sd0),
        .W                ({5'b11110, 5'b11110, 5'b11110, 5'b11110})
    ) u_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    mac_seq #(
        .N_NEIGHBORS      (N),
        .WEIGHT_PRECISION (5),
        .I0_WIDTH         (4),
        .I0_FRAC          (2),
        .H                (5'sd0),
        .W                ({5'b10000, 5'b00000, 5'b00000, 5'b00000})
    ) u_c (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_c)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- monitors / scoreboards ----------------
    always @(negedge clk) begin
        if (bus_a.out_valid) begin
            if (exp_a_q.size() == 0) begin
                check("unexpected_valid_a", 1, 0);
            end else begin
                check("out_a", int'($signed(bus_a.out)), int'($signed(exp_a_q.pop_front())));
                check("latency_a", cyc, cyc_a_q.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (bus_b.out_valid) begin
            if (exp_b_q.size() == 0) begin
                check("unexpected_valid_b", 1, 0);
            end else begin
                check("out_b", int'($signed(bus_b.out)), int'($signed(exp_b_q.pop_front())));
                check("latency_b", cyc, cyc_b_q.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (bus_c.out_valid) begin
            if (exp_c_q.size() == 0) begin
                check("unexpected_valid_c", 1, 0);
            end else begin
                check("out_c", int'($signed(bus_c.out)), int'($signed(exp_c_q.pop_front())));
                check("latency_c", cyc, cyc_c_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Raise start for one cycle on instance 'which' and record the expected
    // result; the sampling edge is cyc+1, the result edge N+1 after that.
    task automatic issue(input int which, input logic [3:0] p, input logic [3:0] i0,
                         input int exp);
        @(negedge clk);
        case (which)
            0: begin
                bus_a.start = 1'b1; bus_a.p_in = p; bus_a.I_0 = i0;
                exp_a_q.push_back(6'(exp)); cyc_a_q.push_back(cyc + 1 + N + 1);
            end
            1: begin
                bus_b.start = 1'b1; bus_b.p_in = p; bus_b.I_0 = i0;
                exp_b_q.push_back(5'(exp)); cyc_b_q.push_back(cyc + 1 + N + 1);
            end
            default: begin
                bus_c.start = 1'b1; bus_c.p_in = p; bus_c.I_0 = i0;
                exp_c_q.push_back(5'(exp)); cyc_c_q.push_back(cyc + 1 + N + 1);
            end
        endcase
        @(negedge clk);
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
        bus_c.start = 1'b0;
    endtask

    // Count negedges with busy high (bounded); a hung FSM shows up as 30.
    task automatic wait_idle(input int which, output int n);
        logic b;
        n = 0;
        for (int i = 0; i < 30; i++) begin
            b = (which == 0) ? bus_a.busy : (which == 1) ? bus_b.busy : bus_c.busy;
            if (!b) break;
            n++;
            @(negedge clk);
        end
        if (n >= 30) check("busy_timeout", n, N + 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus_a.start = 1'b0; bus_a.p_in = '0; bus_a.I_0 = '0;
        bus_b.start = 1'b0; bus_b.p_in = '0; bus_b.I_0 = '0;
        bus_c.start = 1'b0; bus_c.p_in = '0; bus_c.I_0 = '0;

        repeat (3) @(negedge clk);
        check("reset_out", int'($signed(bus_a.out)), 0);
        check("reset_busy", int'(bus_a.busy), 0);
        check("reset_valid", int'(bus_a.out_valid), 0);
        check("reset_state", int'(bus_a.state), int'(ST_IDLE));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Defaults: 2 + (3+1+1+1) = 8, *4 >> 2 = 8; busy for N+1 cycles.
        issue(0, 4'b1111, 4'd4, 8);
        wait_idle(0, n);
        check("busy_cycles", n, N + 1);
        repeat (3) @(negedge clk);
        check("out_hold", int'($signed(bus_a.out)), 8);
        check("valid_is_pulse", int'(bus_a.out_valid), 0);

        // 2 - 6 = -4: I_0=4 -> -4, 3 -> -3, 1 -> floor(-1) = -1.
        issue(0, 4'b0000, 4'd4, -4);  wait_idle(0, n);
        issue(0, 4'b0000, 4'd3, -3);  wait_idle(0, n);
        issue(0, 4'b0000, 4'd1, -1);  wait_idle(0, n);
        issue(0, 4'b1111, 4'd1, 2);   wait_idle(0, n);
        // Mixed: p=0101 -> 2 + 3 - 1 + 1 - 1 = 4, *5 = 20 >> 2 = 5.
        issue(0, 4'b0101, 4'd5, 5);   wait_idle(0, n);

        // Saturation, all weights -2: +8*15=120>>2=30 -> 15; -30 -> -16.
        issue(1, 4'b0000, 4'd15, 15);  wait_idle(1, n);
        issue(1, 4'b1111, 4'd15, -16); wait_idle(1, n);
        // Most negative weight negated exactly: 16*4>>2 = 16 -> 15.
        issue(2, 4'b0000, 4'd4, 15);   wait_idle(2, n);

        // start and p_in churn during ACCUM must not disturb the captured request.
        @(negedge clk);
        bus_a.start = 1'b1; bus_a.p_in = 4'b1111; bus_a.I_0 = 4'd4;
        exp_a_q.push_back(6'd8); cyc_a_q.push_back(cyc + 1 + N + 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus_a.start = (i != 1);
            bus_a.p_in  = (i[0]) ? 4'b1010 : 4'b0000;
            bus_a.I_0   = 4'd1;
        end
        @(negedge clk);
        bus_a.start = 1'b0;
        for (int i = 0; i < 20 && !bus_a.out_valid; i++) @(negedge clk);
        // Re-request on the out_valid cycle: accepted on the very next edge.
        bus_a.start = 1'b1; bus_a.p_in = 4'b0000; bus_a.I_0 = 4'd4;
        exp_a_q.push_back(-6'sd4); cyc_a_q.push_back(cyc + 1 + N + 1);
        @(negedge clk);
        bus_a.start = 1'b0;
        wait_idle(0, n);

        // Reset in the middle of ACCUM: outputs clear at once, no result follows.
        @(negedge clk);
        bus_a.start = 1'b1; bus_a.p_in = 4'b1111; bus_a.I_0 = 4'd4;
        @(negedge clk);
        bus_a.start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_out", int'($signed(bus_a.out)), 0);
        check("abort_busy", int'(bus_a.busy), 0);
        check("abort_valid", int'(bus_a.out_valid), 0);
        check("abort_state", int'(bus_a.state), int'(ST_IDLE));
        repeat (8) @(negedge clk);
        rst_n = 1'b1;
        bus_a.start = 1'b1; bus_a.p_in = 4'b0000; bus_a.I_0 = 4'd3;
        exp_a_q.push_back(-6'sd3); cyc_a_q.push_back(cyc + 1 + N + 1);
        @(negedge clk);
        bus_a.start = 1'b0;
        wait_idle(0, n);

        repeat (10) @(negedge clk);
        check("pending_a", exp_a_q.size(), 0);
        check("pending_b", exp_b_q.size(), 0);
        check("pending_c", exp_c_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mac_seq.md
MAC_SEQ -- requirements
Module: mac_seq

Interface
REQ-001 Parameter N_NEIGHBORS, default 4, meaning number of p-bit inputs (1..16).
REQ-002 Parameter WEIGHT_PRECISION, default 6, meaning signed two's-complement width of H, each weight and out.
REQ-003 Parameter I0_WIDTH, default 4, meaning unsigned scale width.
REQ-004 Parameter I0_FRAC, default 2, meaning fractional bits of I_0 (I0_FRAC <= I0_WIDTH).
REQ-005 Parameter H, default 6'd2, meaning signed bias.
REQ-006 Parameter W, default {6'd1,6'd1,6'd1,6'd3}, meaning packed signed weights; weight i occupies bits [WEIGHT_PRECISION*i +: WEIGHT_PRECISION].
REQ-007 clk  input  1  system clock, all state changes on the rising edge.
REQ-008 rst_n  input  1  asynchronous, active-low reset.
REQ-009 start  input  1  request one evaluation; sampled only in IDLE.
REQ-010 p_in  input  N_NEIGHBORS  p-bits; 1 means +1, 0 means -1.
REQ-011 I_0  input  I0_WIDTH  unsigned fixed-point scale.
REQ-012 busy  output  1  high while state is not IDLE.
REQ-013 out_valid  output  1  one-cycle pulse marking a new out.
REQ-014 out  output  WEIGHT_PRECISION  signed saturated result I_0*(H + sum(W[i]*p_i)).

Function
REQ-015 FSM states: IDLE, ACCUM, SCALE; one shared adder; no combinational path from inputs to outputs.
REQ-016 IDLE with start=1: capture p_in and I_0 into registers, load accumulator with sign-extended H, clear index, go to ACCUM.
REQ-017 ACCUM: each cycle add +W[idx] if p_reg[idx]=1, else -W[idx], then idx+1; after idx=N_NEIGHBORS-1 go to SCALE.
REQ-018 Negation is performed at accumulator width, so the most negative weight negates without wrap.
REQ-019 Accumulator width is WEIGHT_PRECISION+$clog2(N_NEIGHBORS+1)+1 bits, signed; the accumulator never overflows.
REQ-020 SCALE: product = acc * $signed({1'b0,I_0}); scaled = product >>> I0_FRAC (arithmetic, floor toward minus infinity).
REQ-021 Saturation: scaled > 2^(WP-1)-1 gives 2^(WP-1)-1; scaled < -2^(WP-1) gives -2^(WP-1); otherwise the low WP bits.
REQ-022 SCALE registers out, sets out_valid=1 for exactly one cycle, returns to IDLE.
REQ-023 Latency: start sampled at edge k; out/out_valid update at edge k+N_NEIGHBORS+1; busy high for N_NEIGHBORS+1 cycles.
REQ-024 start while busy is ignored; p_in/I_0 changes while busy do not affect the result.
REQ-025 start high in the cycle out_valid is high (state IDLE) is accepted; back-to-back throughput is one result per N_NEIGHBORS+1 cycles.
REQ-026 out holds its last value until the next SCALE.

Reset
REQ-027 rst_n low asynchronously forces state IDLE, busy=0, out_valid=0, out=0, accumulator=0, idx=0, captured registers=0.
REQ-028 Reset mid-evaluation abandons it; no out_valid is produced for the aborted request.
REQ-029 After rst_n rises, the first start is accepted on the next rising edge.

Structure
REQ-030 Shared package mac_pkg holds the FSM state enumeration and the function computing accumulator width.
REQ-031 Sub-module pbit_sat (signed saturate, parametrised input width and WEIGHT_PRECISION) is used for REQ-021.

Verification
REQ-032 Defaults, p_in=1111, I_0=4: out=8, out_valid exactly 5 cycles after start edge, busy high 5 cycles.
REQ-033 Defaults, p_in=0000: I_0=4 gives -4; I_0=3 gives -3; I_0=1 gives -1 (floor); p_in=1111, I_0=1 gives 2.
REQ-034 WP=5, H=0, W all -2: p_in=0000, I_0=15 gives 15 (saturated from 30); p_in=1111, I_0=15 gives -16 (saturated from -30).
REQ-035 WP=5, H=0, W={-16,0,0,0}, p_in=0000, I_0=4: out=15 (no negation wrap).
REQ-036 start pulsed and p_in toggled mid-ACCUM: one out_valid only, result reflects captured p_in; start re-asserted on out_valid cycle begins the next evaluation.
REQ-037 rst_n dropped in ACCUM: outputs zero immediately, no out_valid follows; the next start yields the correct result.
